// File: rtl/dmem_arb_pkg.sv
// Shared constants and FSM encoding for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    // Number of requesters sharing the data memory
    localparam int NREQ = 2;

    // Memory word-index width (16 words)
    localparam int MEM_AW = 4;

    // Requester indices into the req_* / rsp_valid vectors
    localparam int REQ_CORE = 0;
    localparam int REQ_NOC  = 1;

    // Transaction FSM: one request in flight at a time
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-input round-robin arbiter. The grant is combinational from req; the
// pointer moves to the non-granted requester whenever a grant is issued, so a
// requester that loses a tie wins the next one.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    // Grant selection and pointer update
    always_comb begin
        gnt      = '0;
        rr_ptr_d = rr_ptr_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (|gnt) begin
            rr_ptr_d = ~gnt[REQ_NOC];
        end
    end

    // Pointer register; reset gives the core priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core and NoC port share a 16-word memory.
// Handshake: a requester holds req_valid and its payload stable until it sees
// req_ready in the same cycle; the transfer happens on that rising edge.
// Dropping req_valid afterwards does not cancel the accepted transaction.
// Timeline: accept at T, memory strobe at T+1 (ACCESS), rsp_valid at T+2 (RESP).
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [1:0][31:0]       req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic [31:0]            mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [1:0]             dbg_state
);

    import dmem_arb_pkg::*;

    arb_state_e        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              we_q,        we_d;
    logic [31:0]       addr_q,      addr_d;
    logic              mem_we_q,    mem_we_d;
    logic              mem_re_q,    mem_re_d;
    logic [31:0]       mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic [1:0]        arb_req;
    logic [1:0]        gnt;
    logic              gnt_idx;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ok;
    logic              lat_ok;

    // Only offer requests to the arbiter while idle and out of reset
    assign arb_req = (state_q == ST_IDLE && !rst) ? req_valid : 2'b00;

    rr_arbiter2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (gnt)
    );

    assign gnt_idx   = gnt[REQ_NOC];
    assign sel_addr  = req_addr[gnt_idx];
    assign sel_wdata = req_wdata[gnt_idx];
    // Addresses above the memory index range are errors and never strobe memory
    assign sel_ok    = (sel_addr >> MEM_AW) == 32'd0;
    assign lat_ok    = (addr_q >> MEM_AW) == 32'd0;

    // Next-state and next-output logic; every output register defaults to 0
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    owner_d     = gnt_idx;
                    we_d        = req_we[gnt_idx];
                    addr_d      = sel_addr;
                    mem_we_d    = sel_ok & req_we[gnt_idx];
                    mem_re_d    = sel_ok & ~req_we[gnt_idx];
                    mem_addr_d  = 32'(sel_addr[MEM_AW-1:0]);
                    mem_wdata_d = sel_wdata;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rsp_valid_d[owner_q] = 1'b1;
                rsp_err_d            = ~lat_ok;
                rsp_rdata_d          = (lat_ok && !we_q) ? mem_rdata : '0;
                state_d              = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, latched request and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = gnt;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural 16-word memory, vector table, scoreboard
// of expected responses with their due cycle, and corner-case sequences.
module tb_dmem_arbiter;

    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [1:0]             req_valid = '0;
    logic [1:0]             req_we    = '0;
    logic [1:0][31:0]       req_addr  = '0;
    logic [1:0][DATA_W-1:0] req_wdata = '0;
    logic [1:0]             req_ready;
    logic [1:0]             rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   mem_we;
    logic                   mem_re;
    logic [31:0]            mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic [1:0]             dbg_state;

    dmem_arbiter #(.DATA_W(DATA_W), .MEM_AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- memory model ----------------
    logic              mem_clr = 1'b1;
    logic [DATA_W-1:0] tb_mem [16];
    assign mem_rdata = tb_mem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= '0;
        end else if (mem_we) begin
            tb_mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    // entry = {due_cycle[29:0], owner, err, rdata[31:0]}
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp actual rsp_valid=%b expected none (t=%0t)", rsp_valid, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(mon_e[63:34]));
                check("rsp_owner", 64'(rsp_valid), 64'(2'b01 << mon_e[33]));
                check("rsp_err", 64'(rsp_err), 64'(mon_e[32]));
                check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[31:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge in IDLE; returns at a negedge in IDLE after the response.
    task automatic issue(input int who, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input bit exp_err, input logic [31:0] exp_rd);
        bit got = 1'b0;
        req_valid[who] = 1'b1;
        req_we[who]    = we;
        req_addr[who]  = addr;
        req_wdata[who] = wd;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (req_ready[who]) begin
                got = 1'b1;
                check("ready_onehot", 64'(req_ready), 64'(2'b01 << who));
                exp_q.push_back({30'(cyc + 2), 1'(who), exp_err, exp_rd});
            end
            @(negedge clk);
        end
        // Drop valid one cycle after acceptance; the transaction must complete
        req_valid[who] = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept_timeout actual=no_ready expected=ready who=%0d", who);
        end else begin
            #1;
            check("mem_we", 64'(mem_we), 64'(we && !exp_err));
            check("mem_re", 64'(mem_re), 64'(!we && !exp_err));
            if (!exp_err) check("mem_addr", 64'(mem_addr), 64'(addr[3:0]));
            if (we && !exp_err) check("mem_wdata", 64'(mem_wdata), 64'(wd));
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] ref_mem [4];
    int          grant_cyc [4];
    int          n_grants;

    initial begin
        tbl[0] = '{0, 1'b1, 32'h0000_0003, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1] = '{0, 1'b0, 32'h0000_0003, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h0};
        tbl[3] = '{1, 1'b1, 32'h0000_0007, 32'h1234_5678, 1'b0, 32'h0};
        tbl[4] = '{0, 1'b0, 32'h0000_0007, 32'h0,         1'b0, 32'h1234_5678};
        tbl[5] = '{0, 1'b0, 32'h0000_000F, 32'h0,         1'b0, 32'h0};
        tbl[6] = '{1, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 1'b1, 32'h0};
        tbl[7] = '{1, 1'b0, 32'h0000_0003, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[8] = '{0, 1'b1, 32'h0000_000F, 32'hA5A5_A5A5, 1'b0, 32'h0};
        tbl[9] = '{1, 1'b0, 32'h0000_000F, 32'h0,         1'b0, 32'hA5A5_A5A5};

        // Reset: outputs zero, no grant even with both requests present
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_mem_we", 64'(mem_we), 64'h0);
        check("rst_mem_re", 64'(mem_re), 64'h0);
        check("rst_mem_addr", 64'(mem_addr), 64'h0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        check("rst_rsp_err", 64'(rsp_err), 64'h0);
        check("rst_state", 64'(dbg_state), 64'h0);
        req_valid = 2'b00;
        @(negedge clk);
        mem_clr = 1'b0;
        rst     = 1'b0;

        // Table of single transactions
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].rd);
        end

        // Round-robin from reset: both valid continuously, grants 0,1,0,1
        do_reset();
        req_valid    = 2'b11;
        req_we       = 2'b00;
        req_addr[0]  = 32'h3;
        req_addr[1]  = 32'h7;
        n_grants     = 0;
        for (int k = 0; k < 20 && n_grants < 4; k++) begin
            #1;
            if (req_ready != 2'b00) begin
                check("rr_grant", 64'(req_ready), 64'(2'b01 << (n_grants % 2)));
                grant_cyc[n_grants] = cyc;
                if (n_grants > 0) check("rr_spacing", 64'(cyc - grant_cyc[n_grants-1]), 64'd3);
                exp_q.push_back({30'(cyc + 2), 1'(n_grants % 2), 1'b0,
                                 (n_grants % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678});
                n_grants++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        check("rr_grant_count", 64'(n_grants), 64'd4);
        repeat (3) @(negedge clk);

        // Reset during ACCESS of a core write: dropped, memory keeps old value
        issue(0, 1'b1, 32'h5, 32'h55AA_55AA, 1'b0, 32'h0);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h5;
        req_wdata[0] = 32'hBADB_AD00;
        #1;
        check("abort_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        check("abort_in_access", 64'(dbg_state), 64'h1);
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        #1;
        check("abort_mem_we", 64'(mem_we), 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(rsp_valid), 64'h0);
        end
        rst = 1'b0;
        issue(0, 1'b0, 32'h5, 32'h0, 1'b0, 32'h55AA_55AA);

        // Random traffic over words 8..11
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = $urandom;
            issue(i % 2, 1'b1, 32'(8 + i), ref_mem[i], 1'b0, 32'h0);
        end
        for (int i = 0; i < 10; i++) begin
            int          who;
            int          idx;
            bit          we;
            logic [31:0] wd;
            who = $urandom_range(0, 1);
            idx = $urandom_range(0, 3);
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (we) begin
                issue(who, 1'b1, 32'(8 + idx), wd, 1'b0, 32'h0);
                ref_mem[idx] = wd;
            end else begin
                issue(who, 1'b0, 32'(8 + idx), wd, 1'b0, ref_mem[idx]);
            end
        end

        // Drain scoreboard
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
